// File: rtl/lfo_pkg.sv
// Shared constants, types and the quadrant-folding helper for the tremolo LFO.
// The cordic only covers 0..90 degrees, so the full-cycle phase is folded here.
package lfo_pkg;

    localparam int unsigned PHASE_W_DEF = 24;
    localparam int unsigned ANGLE_W     = 9;
    localparam int unsigned FRAC_W      = 10;
    localparam int unsigned PROD_W      = FRAC_W + ANGLE_W;

    localparam logic [ANGLE_W-1:0] ANGLE_90 = 9'd402;

    typedef logic [1:0] quad_t;

    // Odd quadrants run the fraction backwards so the first-quadrant sine
    // rises and falls symmetrically across each half cycle.
    function automatic logic [ANGLE_W-1:0] fold_angle(input quad_t q,
                                                      input logic [FRAC_W-1:0] f);
        logic [FRAC_W-1:0] fm;
        logic [PROD_W-1:0] prod;
        fm   = q[0] ? ~f : f;
        prod = PROD_W'(fm) * PROD_W'(ANGLE_90);
        return prod[PROD_W-1:FRAC_W];
    endfunction

endpackage

// File: rtl/lfo_phase_acc.sv
// Stage 0 of the LFO pipeline: phase accumulator with sync-over-tick priority.
// Only the quadrant and fraction bits are exported; the low bits just carry precision.
module lfo_phase_acc
    import lfo_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEF,
    parameter int unsigned TOP_W   = 2 + FRAC_W
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               tick_i,
    input  logic               sync_i,
    input  logic [PHASE_W-1:0] rate_i,
    output logic [TOP_W-1:0]   phase_top_o,
    output logic               valid_o
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;
    logic               v0_q;
    logic               v0_d;

    always_comb begin
        phase_d = phase_q;
        v0_d    = tick_i | sync_i;
        if (sync_i) begin
            phase_d = '0;
        end else if (tick_i) begin
            phase_d = phase_q + rate_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q <= '0;
            v0_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            v0_q    <= v0_d;
        end
    end

    assign phase_top_o = phase_q[PHASE_W-1 -: TOP_W];
    assign valid_o     = v0_q;

endmodule

// File: rtl/lfo_phase_gen.sv
// Tremolo LFO front/back end: phase accumulation, quadrant fold to the cordic,
// and sign restoration of the returned first-quadrant sine.
module lfo_phase_gen
    import lfo_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               tick_i,
    input  logic               sync_i,
    input  logic [PHASE_W-1:0] rate_i,
    output logic [ANGLE_W-1:0] angle_o,
    input  logic [7:0]         sin_i,
    output logic [8:0]         lfo_o,
    output logic               valid_o
);

    localparam int unsigned TOP_W = 2 + FRAC_W;

    logic [TOP_W-1:0]   phase_top;
    logic               v0;
    quad_t              quad;
    logic [FRAC_W-1:0]  frac;

    logic [ANGLE_W-1:0] angle_q;
    logic [ANGLE_W-1:0] angle_d;
    logic               q1_q;
    logic               q1_d;
    logic               v1_q;
    logic               v1_d;

    logic [8:0]         lfo_mag;
    logic [8:0]         lfo_q;
    logic [8:0]         lfo_d;
    logic               valid_q;
    logic               valid_d;

    lfo_phase_acc #(
        .PHASE_W (PHASE_W),
        .TOP_W   (TOP_W)
    ) u_acc (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .tick_i      (tick_i),
        .sync_i      (sync_i),
        .rate_i      (rate_i),
        .phase_top_o (phase_top),
        .valid_o     (v0)
    );

    assign quad = phase_top[TOP_W-1 -: 2];
    assign frac = phase_top[FRAC_W-1:0];

    always_comb begin
        angle_d = angle_q;
        q1_d    = q1_q;
        v1_d    = v0;
        if (v0) begin
            angle_d = fold_angle(quad, frac);
            q1_d    = quad[1];
        end
    end

    // sin_i is the combinational cordic response to angle_q, so it is valid here.
    always_comb begin
        lfo_mag = {1'b0, sin_i};
        lfo_d   = lfo_q;
        valid_d = v1_q;
        if (v1_q) begin
            lfo_d = q1_q ? (~lfo_mag + 9'd1) : lfo_mag;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            angle_q <= '0;
            q1_q    <= 1'b0;
            v1_q    <= 1'b0;
            lfo_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            angle_q <= angle_d;
            q1_q    <= q1_d;
            v1_q    <= v1_d;
            lfo_q   <= lfo_d;
            valid_q <= valid_d;
        end
    end

    assign angle_o = angle_q;
    assign lfo_o   = lfo_q;
    assign valid_o = valid_q;

endmodule
